// File: rtl/sync_dp_ram_ind_r_w.sv
// Simple dual-port RAM: one write port and one independent read port on a single clock.
// SYNC_READ selects a registered read port (block RAM style) or a combinational one
// (distributed RAM style). The storage array is never reset.
module sync_dp_ram_ind_r_w #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_DEPTH = 1024,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SYNC_READ  = 1
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  WrEn_SI,
  input  logic [ADDR_WIDTH-1:0] RdAddr_DI,
  input  logic [ADDR_WIDTH-1:0] WrAddr_DI,
  input  logic [DATA_WIDTH-1:0] WrData_DI,
  output logic [DATA_WIDTH-1:0] RdData_DO
);

  // Index width actually needed to address DATA_DEPTH words.
  localparam int unsigned IdxW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam int unsigned AddrW1 = ADDR_WIDTH + 1;
  // Depth widened by one bit so it can be compared against any address value.
  localparam logic [ADDR_WIDTH:0] DepthL = AddrW1'(DATA_DEPTH);

  if (DATA_DEPTH == 0 || 64'(DATA_DEPTH) > (64'd1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("sync_dp_ram_ind_r_w: DATA_DEPTH must be in 1 .. 2**ADDR_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  logic            wr_hit;
  logic            rd_hit;
  logic [IdxW-1:0] wr_idx;
  logic [IdxW-1:0] rd_idx;

  // Out-of-range addresses never touch the array.
  always_comb begin
    wr_hit = ({1'b0, WrAddr_DI} < DepthL);
    rd_hit = ({1'b0, RdAddr_DI} < DepthL);
    wr_idx = WrAddr_DI[IdxW-1:0];
    rd_idx = RdAddr_DI[IdxW-1:0];
  end

  if (SYNC_READ != 0) begin : g_sync_read
    logic [DATA_WIDTH-1:0] rd_q;

    // Write port and registered read port share one process so the reset that clears the
    // output register also blocks writes; the array itself is left untouched by reset.
    // Read returns pre-write contents on a same-address collision.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
        rd_q <= '0;
      end else begin
        if (WrEn_SI && wr_hit) begin
          mem_q[wr_idx] <= WrData_DI;
        end
        rd_q <= rd_hit ? mem_q[rd_idx] : '0;
      end
    end

    assign RdData_DO = rd_q;
  end else begin : g_async_read
    // Write port; writes while reset is asserted are dropped.
    always_ff @(posedge Clk_CI) begin
      if (Rst_RBI && WrEn_SI && wr_hit) begin
        mem_q[wr_idx] <= WrData_DI;
      end
    end

    // Combinational read port.
    always_comb begin
      RdData_DO = rd_hit ? mem_q[rd_idx] : '0;
    end
  end

endmodule

// File: tb/tb_sync_dp_ram_ind_r_w.sv
// Directed bench for sync_dp_ram_ind_r_w: registered and combinational read variants at the
// default size, plus a registered 6-word instance for out-of-range behaviour.
module tb_sync_dp_ram_ind_r_w;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        we;
  logic [9:0]  wa;
  logic [9:0]  ra;
  logic [31:0] wd;
  logic [31:0] rd_sync;
  logic [31:0] rd_async;

  logic        s_we;
  logic [2:0]  s_wa;
  logic [2:0]  s_ra;
  logic [31:0] s_wd;
  logic [31:0] rd_small;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] model   [1024];
  logic [31:0] model_s [6];
  logic [31:0] q_sync  [$];
  logic [31:0] q_async [$];
  logic [31:0] q_small [$];

  sync_dp_ram_ind_r_w #(
    .ADDR_WIDTH(10),
    .DATA_DEPTH(1024),
    .DATA_WIDTH(32),
    .SYNC_READ (1)
  ) u_sync (
    .Clk_CI   (clk),
    .Rst_RBI  (rst_n),
    .WrEn_SI  (we),
    .RdAddr_DI(ra),
    .WrAddr_DI(wa),
    .WrData_DI(wd),
    .RdData_DO(rd_sync)
  );

  sync_dp_ram_ind_r_w #(
    .ADDR_WIDTH(10),
    .DATA_DEPTH(1024),
    .DATA_WIDTH(32),
    .SYNC_READ (0)
  ) u_async (
    .Clk_CI   (clk),
    .Rst_RBI  (rst_n),
    .WrEn_SI  (we),
    .RdAddr_DI(ra),
    .WrAddr_DI(wa),
    .WrData_DI(wd),
    .RdData_DO(rd_async)
  );

  sync_dp_ram_ind_r_w #(
    .ADDR_WIDTH(3),
    .DATA_DEPTH(6),
    .DATA_WIDTH(32),
    .SYNC_READ (1)
  ) u_small (
    .Clk_CI   (clk),
    .Rst_RBI  (rst_n),
    .WrEn_SI  (s_we),
    .RdAddr_DI(s_ra),
    .WrAddr_DI(s_wa),
    .WrData_DI(s_wd),
    .RdData_DO(rd_small)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock of the 1024-word pair. Registered read expects pre-write data, combinational
  // read (sampled after the edge) expects post-write data.
  task automatic step(input logic w, input logic [9:0] a, input logic [31:0] d,
                      input logic [9:0] r, input bit chk);
    we = w; wa = a; wd = d; ra = r;
    if (chk) q_sync.push_back(model[r]);
    if (w && rst_n) model[a] = d;
    if (chk) q_async.push_back(model[r]);
    @(posedge clk);
    #1;
    if (chk) begin
      check("sync_rd", rd_sync, q_sync.pop_front());
      check("async_rd", rd_async, q_async.pop_front());
    end
    we = 1'b0;
  endtask

  // One clock of the 6-word instance.
  task automatic step_s(input logic w, input logic [2:0] a, input logic [31:0] d,
                        input logic [2:0] r, input bit chk);
    s_we = w; s_wa = a; s_wd = d; s_ra = r;
    if (chk) q_small.push_back((r < 3'd6) ? model_s[r] : 32'd0);
    if (w && rst_n && a < 3'd6) model_s[a] = d;
    @(posedge clk);
    #1;
    if (chk) check("small_rd", rd_small, q_small.pop_front());
    s_we = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    we = 1'b0; wa = '0; wd = '0; ra = '0;
    s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra = '0;

    // Output register held at zero while in reset.
    #2;
    check("rst_sync", rd_sync, 32'd0);
    check("rst_small", rd_small, 32'd0);
    step(1'b1, 10'd12, 32'h1234_5678, 10'd0, 1'b0);
    check("rst_hold_sync", rd_sync, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read with one-cycle latency.
    step(1'b1, 10'd5, 32'hDEAD_BEEF, 10'd0, 1'b0);
    step(1'b0, 10'd0, 32'd0, 10'd5, 1'b1);

    // Same-address read/write collision.
    step(1'b1, 10'd7, 32'h2222_2222, 10'd0, 1'b0);
    step(1'b1, 10'd7, 32'h1111_1111, 10'd7, 1'b1);
    step(1'b0, 10'd0, 32'd0, 10'd7, 1'b1);

    // Reset pulse mid-operation: contents survive, writes during reset are dropped.
    step(1'b1, 10'd3, 32'h0000_0055, 10'd0, 1'b0);
    step(1'b1, 10'd9, 32'h0000_0099, 10'd3, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_assert_sync", rd_sync, 32'd0);
    step(1'b1, 10'd9, 32'h0000_0077, 10'd3, 1'b0);
    check("rst_pulse_hold", rd_sync, 32'd0);
    #2;
    rst_n = 1'b1;
    step(1'b0, 10'd0, 32'd0, 10'd3, 1'b1);
    step(1'b0, 10'd0, 32'd0, 10'd9, 1'b1);

    // Fill every word with its address, then read back sequentially.
    for (int i = 0; i < 1024; i++) step(1'b1, 10'(i), 32'(i), 10'd0, 1'b0);
    for (int i = 0; i < 1024; i++) step(1'b0, 10'd0, 32'd0, 10'(i), 1'b1);

    // Disabled writes with changing address/data leave memory unchanged.
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 10'($urandom_range(0, 1023)), $urandom, 10'd0, 1'b0);
    end
    for (int i = 0; i < 1024; i++) step(1'b0, 10'd0, 32'd0, 10'(i), 1'b1);

    // Out-of-range writes and reads on the 6-word instance.
    for (int i = 0; i < 6; i++) step_s(1'b1, 3'(i), 32'h10 + 32'(i), 3'd0, 1'b0);
    step_s(1'b1, 3'd6, 32'h0000_00AA, 3'd6, 1'b1);
    step_s(1'b1, 3'd7, 32'h0000_00BB, 3'd7, 1'b1);
    step_s(1'b0, 3'd0, 32'd0, 3'd6, 1'b1);
    for (int i = 0; i < 6; i++) step_s(1'b0, 3'd0, 32'd0, 3'(i), 1'b1);
    step_s(1'b0, 3'd0, 32'd0, 3'd7, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sync_dp_ram_ind_r_w.md
SYNC_DP_RAM_IND_R_W -- requirements
Module: sync_dp_ram_ind_r_w

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10: width of read and write address ports.
REQ-002 SHALL have parameter DATA_DEPTH, default 1024: number of storage words, 1 <= DATA_DEPTH <= 2**ADDR_WIDTH.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: width of one word.
REQ-004 SHALL have parameter SYNC_READ, default 1: 1 = registered read port (SyncDpRam_ind_r_w behaviour); 0 = combinational read port (AsyncDpRam behaviour).
REQ-005 SHALL have port Clk_CI, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port Rst_RBI, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port WrEn_SI, input, 1 bit: write enable.
REQ-008 SHALL have port RdAddr_DI, input, ADDR_WIDTH bits: read address, independent of write address.
REQ-009 SHALL have port WrAddr_DI, input, ADDR_WIDTH bits: write address.
REQ-010 SHALL have port WrData_DI, input, DATA_WIDTH bits: write data.
REQ-011 SHALL have port RdData_DO, output, DATA_WIDTH bits: read data.

Function
REQ-012 SHALL store DATA_DEPTH words of DATA_WIDTH bits, one write port and one read port, usable in the same cycle.
REQ-013 SHALL write WrData_DI to word WrAddr_DI on the rising edge of Clk_CI when WrEn_SI=1 and WrAddr_DI < DATA_DEPTH; no other word changes.
REQ-014 SHALL ignore writes with WrAddr_DI >= DATA_DEPTH; no word changes.
REQ-015 SHALL not alter memory when WrEn_SI=0, regardless of other inputs.
REQ-016 SYNC_READ=1: SHALL capture word RdAddr_DI into an output register on every rising edge; RdData_DO equals that register; latency 1 cycle, no read enable.
REQ-017 SYNC_READ=1, read and write to same address in same edge: SHALL return the old (pre-write) contents; the new data is visible on the next read edge.
REQ-018 SYNC_READ=0: SHALL drive RdData_DO combinationally from word RdAddr_DI, latency 0; a write becomes visible immediately after the writing edge.
REQ-019 SHALL drive RdData_DO = 0 for RdAddr_DI >= DATA_DEPTH (registered in SYNC_READ=1, combinational in SYNC_READ=0).
REQ-020 SHALL reject at elaboration DATA_DEPTH = 0 or DATA_DEPTH > 2**ADDR_WIDTH.
REQ-021 SHALL be written so FPGA tools infer block RAM (SYNC_READ=1) or distributed RAM (SYNC_READ=0): no reset on the storage array.

Reset
REQ-022 While Rst_RBI=0, SHALL hold the SYNC_READ=1 output register at 0, so RdData_DO = 0 asynchronously upon reset assertion.
REQ-023 SHALL not clear or modify the storage array on reset; written words survive a reset pulse; unwritten words are undefined.
REQ-024 Writes on edges while Rst_RBI=0 SHALL be ignored; first read capture occurs on the first rising edge after deassertion.

Verification
REQ-025 Reset then write 0xDEADBEEF to addr 5, next cycle RdAddr=5 (SYNC_READ=1) -> RdData_DO=0 during reset, 0xDEADBEEF one edge after address applied.
REQ-026 Same edge: WrEn=1 WrAddr=7 data 0x11111111 over prior 0x22222222, RdAddr=7 -> SYNC_READ=1 returns 0x22222222 then 0x11111111; SYNC_READ=0 returns 0x11111111 right after the edge.
REQ-027 Write every address 0..DATA_DEPTH-1 with value = address, then read sequentially -> each read returns its address, with 1-cycle (sync) or 0-cycle (async) latency.
REQ-028 DATA_DEPTH=6, ADDR_WIDTH=3: write 0xAA to addr 6, read addr 6 -> RdData_DO=0, addrs 0..5 unchanged.
REQ-029 Write 0x55 to addr 3, pulse Rst_RBI low mid-operation, read addr 3 -> RdData_DO=0 while in reset, 0x55 one edge after deassertion.
REQ-030 WrEn_SI=0 with varying WrAddr/WrData for 10 cycles -> all previously written words read back unchanged.
